// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
//  Module   : full_adder
//  Brief    : Registered WIDTH-bit ripple-carry adder/subtractor with status
//             flags (carry, signed overflow, zero, negative) and a valid
//             strobe. One-cycle latency, one operation per cycle.
//  Revision : 1.0  initial release
// ============================================================================
module full_adder #(
   parameter int WIDTH = 8
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic [WIDTH-1:0] InA,
   input  logic [WIDTH-1:0] InB,
   input  logic             Cin,
   input  logic             Sub,
   input  logic             InValid,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             Ovf,
   output logic             Zero,
   output logic             Neg,
   output logic             OutValid
);

   // Subtraction is A + ~B + 1, so B is inverted per bit and the chain is
   // seeded with 1; the external carry-in only matters for addition.
   logic [WIDTH-1:0] w_bEff;
   logic [WIDTH:0]   w_carry;
   logic [WIDTH-1:0] w_sum;
   logic             w_ovf;
   logic             w_zero;

   assign w_carry[0] = Sub ? 1'b1 : Cin;

   // Ripple chain of one-bit full-adder cells.
   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_cell
         assign w_bEff[i]      = InB[i] ^ Sub;
         assign w_sum[i]       = InA[i] ^ w_bEff[i] ^ w_carry[i];
         assign w_carry[i + 1] = (InA[i] & w_bEff[i])
                               | (InA[i] & w_carry[i])
                               | (w_bEff[i] & w_carry[i]);
      end
   endgenerate

   // Signed overflow: carry into the MSB disagrees with carry out of it.
   assign w_ovf  = w_carry[WIDTH] ^ w_carry[WIDTH-1];
   // Flags look only at the truncated result, never at the carry-out.
   assign w_zero = (w_sum == '0);

   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_ovf;
   logic             r_zero;
   logic             r_neg;
   logic             r_outValid;

   // Result register: reset wins, new result on valid, otherwise hold data.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_sum      <= '0;
         r_cout     <= 1'b0;
         r_ovf      <= 1'b0;
         r_zero     <= 1'b1;
         r_neg      <= 1'b0;
         r_outValid <= 1'b0;
      end else if (InValid) begin
         r_sum      <= w_sum;
         r_cout     <= w_carry[WIDTH];
         r_ovf      <= w_ovf;
         r_zero     <= w_zero;
         r_neg      <= w_sum[WIDTH-1];
         r_outValid <= 1'b1;
      end else begin
         r_outValid <= 1'b0;
      end
   end

   assign S        = r_sum;
   assign Cout     = r_cout;
   assign Ovf      = r_ovf;
   assign Zero     = r_zero;
   assign Neg      = r_neg;
   assign OutValid = r_outValid;

endmodule
`default_nettype wire

// File: tb/tb_full_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_full_adder
//  Brief    : Directed and randomised checks of full_adder against a
//             behavioural arithmetic model, with a result scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_full_adder;

   localparam int W = 8;

   typedef struct packed {
      logic [W-1:0] s;
      logic         cout;
      logic         ovf;
      logic         zero;
      logic         neg;
   } res_t;

   logic         Clk = 1'b0;
   logic         Rst = 1'b1;
   logic [W-1:0] InA = '0;
   logic [W-1:0] InB = '0;
   logic         Cin = 1'b0;
   logic         Sub = 1'b0;
   logic         InValid = 1'b0;
   logic [W-1:0] S;
   logic         Cout;
   logic         Ovf;
   logic         Zero;
   logic         Neg;
   logic         OutValid;

   int   checks = 0;
   int   errors = 0;
   res_t q[$];
   res_t lastRes;
   logic expValid;

   full_adder #(.WIDTH(W)) dut (
      .Clk(Clk), .Rst(Rst), .InA(InA), .InB(InB), .Cin(Cin), .Sub(Sub),
      .InValid(InValid), .S(S), .Cout(Cout), .Ovf(Ovf), .Zero(Zero),
      .Neg(Neg), .OutValid(OutValid)
   );

   always #5 Clk = ~Clk;

   // Behavioural model using wide integer arithmetic.
   function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, input logic sub);
      res_t         r;
      logic [W-1:0] bEff;
      logic [W:0]   full;
      bEff   = sub ? ~b : b;
      full   = {1'b0, a} + {1'b0, bEff} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
      r.s    = full[W-1:0];
      r.cout = full[W];
      r.ovf  = (a[W-1] == bEff[W-1]) && (r.s[W-1] != a[W-1]);
      r.zero = (r.s == '0);
      r.neg  = r.s[W-1];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock of stimulus followed by a full comparison of the outputs.
   task automatic step(input string name, input logic rst, input logic valid,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub);
      @(negedge Clk);
      Rst = rst; InValid = valid; InA = a; InB = b; Cin = cin; Sub = sub;
      if (rst) begin
         lastRes  = '{s: '0, cout: 1'b0, ovf: 1'b0, zero: 1'b1, neg: 1'b0};
         expValid = 1'b0;
      end else if (valid) begin
         q.push_back(model(a, b, cin, sub));
         expValid = 1'b1;
      end else begin
         expValid = 1'b0;
      end
      @(posedge Clk);
      #1;
      if (!rst && valid) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: scoreboard empty observed 0 expected 1 entry", name);
         end else begin
            lastRes = q.pop_front();
         end
      end
      chk({name, ".S"},        S,        lastRes.s);
      chk({name, ".Cout"},     Cout,     lastRes.cout);
      chk({name, ".Ovf"},      Ovf,      lastRes.ovf);
      chk({name, ".Zero"},     Zero,     lastRes.zero);
      chk({name, ".Neg"},      Neg,      lastRes.neg);
      chk({name, ".OutValid"}, OutValid, expValid);
   endtask

   initial begin
      lastRes  = '{s: '0, cout: 1'b0, ovf: 1'b0, zero: 1'b1, neg: 1'b0};
      expValid = 1'b0;

      // Reset with a concurrent operation that must be discarded.
      step("reset",        1'b1, 1'b1, 8'hFF, 8'h01, 1'b0, 1'b0);
      step("postReset",    1'b0, 1'b0, 8'h12, 8'h34, 1'b0, 1'b0);
      // Directed arithmetic cases.
      step("zeroAdd",      1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
      step("wrapCarry",    1'b0, 1'b1, 8'hFF, 8'h01, 1'b0, 1'b0);
      step("posOvf",       1'b0, 1'b1, 8'h7F, 8'h01, 1'b0, 1'b0);
      step("subBorrow",    1'b0, 1'b1, 8'h05, 8'h07, 1'b0, 1'b1);
      step("subCinIgnore", 1'b0, 1'b1, 8'h05, 8'h07, 1'b1, 1'b1);
      step("subNoBorrow",  1'b0, 1'b1, 8'h07, 8'h05, 1'b0, 1'b1);
      step("negOvf",       1'b0, 1'b1, 8'h80, 8'hFF, 1'b0, 1'b0);
      // Back-to-back, then idle hold.
      step("b2bAddCin",    1'b0, 1'b1, 8'h10, 8'h20, 1'b1, 1'b0);
      step("b2bSubOvf",    1'b0, 1'b1, 8'h80, 8'h01, 1'b0, 1'b1);
      step("idleHold",     1'b0, 1'b0, 8'hAA, 8'h55, 1'b1, 1'b0);
      step("idleHold2",    1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      // Randomised operands.
      for (int i = 0; i < 16; i++) begin
         step("rand", 1'b0, 1'($urandom_range(0, 3) != 0),
              8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      end
      // Mid-stream reset clears the held result.
      step("reset2",       1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      step("afterReset2",  1'b0, 1'b1, 8'h01, 8'h01, 1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Guard against a stalled run.
   initial begin
      #100000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
